scalar_wb_arbiter: RTL and testbench
====================================

Name: scalar_wb_arbiter

Overview:
Shares the scalar register file's single write port (RD/WD/WES) among N_REQ writeback requesters, e.g. ALU, load unit and vector-reduction unit, using round-robin arbitration and a registered output stage. Holds a 32-entry pending-write scoreboard that the issue stage claims on dispatch and that clears on commit. Read-operand hazard flags come from this scoreboard. A drain FSM quiesces all writebacks before program end or context switch.

Parameters:
WIDTH, 19, data width of WD, matching the register-file write data.
N_REQ, 3, number of writeback requesters (2..8).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  N_REQ  requester i holds a write
req_rd  in  5*N_REQ  destination register, slice i
req_wd  in  WIDTH*N_REQ  write data, slice i
req_ready  out  N_REQ  one-hot grant; write accepted this cycle
wr_en  out  1  to RF WES
wr_addr  out  5  to RF RD
wr_data  out  WIDTH  to RF WD
claim_valid  in  1  issue stage reserves a destination
claim_rd  in  5  register being reserved
claim_ready  out  1  reservation accepted
rs1, rs2, rs3  in  5 each  operand addresses being read
haz1, haz2, haz3  out  1 each  operand has a pending write
drain_req  in  1  request quiesce
drained  out  1  all writes committed, no pending
commit_cnt  out  16  saturating count of committed writes

Behaviour:
- Reset (async): wr_en=0, wr_addr=0, wr_data=0, pending=0, rr_ptr=0, state=IDLE, drained=0, commit_cnt=0. req_ready and claim_ready read 0 while rst=1.
- Arbitration (combinational): search req_valid starting at rr_ptr, wrapping modulo N_REQ. The first valid requester gets req_ready=1; all others get 0. At most one grant per cycle.
- On grant to i: rr_ptr <= (i+1) mod N_REQ. With no grant, rr_ptr holds.
- Requesters hold valid/rd/wd stable until they see ready. The arbiter never drops an accepted write.
- Output stage: an accepted write appears on wr_en/wr_addr/wr_data on the next edge (latency 1). With no grant, wr_en <= 0; wr_addr/wr_data hold their last value. The RF always accepts, so there is no backpressure.
- Commit: the edge where wr_en=1 writes the RF. On the same edge, pending[wr_addr] is cleared and commit_cnt increments (saturating at 0xFFFF).
- Claim: claim_ready = claim_valid & ~pending[claim_rd] & (state==IDLE).
  - On an accepted claim, pending[claim_rd] <= 1.
  - A WAW claim on an already pending register is refused; issue retries.
- Claim and commit to the same register on the same edge: commit clears the old bit. claim_ready sees the old bit=1, so the claim is refused and retried next cycle. The bit ends at 0.
- Claim and commit to different registers on the same edge are independent.
- Writes without a prior claim are legal; clearing an unset bit is a no-op. Register 0 is treated like any other register.
- Hazards: hazN = pending[rsN], combinational. There is no bypass, because the bit drops on the same edge the RF takes the data.
- Drain FSM, states IDLE, DRAIN, DONE:
  - IDLE -> DRAIN when drain_req=1.
  - DRAIN: claims blocked; arbitration continues. DRAIN -> DONE when pending==0, wr_en==0 and req_valid==0.
  - DONE: drained=1; claims blocked; arbitration continues. DONE -> IDLE when drain_req=0, and drained drops on that edge.
  - Reset in any state returns to IDLE and loses in-flight writes; the pending scoreboard is cleared.

Decomposition:
- Shared package scalar_rf_pkg: REG_ADDR_W=5, NUM_REGS=32, reg_addr_t, wb_state_t enum {IDLE, DRAIN, DONE}, COMMIT_CNT_W=16.
- Sub-module rr_arbiter (N parameter) holds the pointer and produces the one-hot grant plus encoded index, with clk/rst.
- Scoreboard, output register and FSM live in scalar_wb_arbiter.

Test Plan:
- Reset mid-traffic: pending=0xFFFF_FFFF, req_valid=3'b111, assert rst -> same cycle req_ready=0, wr_en=0; after release pending=0, rr_ptr=0, first grant to requester 0.
- Round-robin: req_valid=3'b111 held, distinct rd 1/2/3 -> grants 0,1,2,0 on consecutive cycles; wr_addr sequence 1,2,3,1 one cycle later; commit_cnt=4.
- Scoreboard hazard: claim r5 accepted -> haz1=1 with rs1=5. Requester 1 writes r5 with wd=19'h7ABCD -> haz1 falls the cycle after wr_en=1 with wr_data=19'h7ABCD.
- WAW/same-edge: r7 pending, claim r7 on the commit edge -> claim_ready=0; next cycle claim_ready=1 and pending[7]=1.
- Drain: pending r3 plus one queued write to r3, drain_req=1 -> claim_ready=0 during DRAIN; drained=1 one cycle after the r3 commit; drain_req=0 -> drained=0 and state IDLE.
- Saturation: force 65536 commits -> commit_cnt stays 0xFFFF.

Source files
------------

// File: rtl/scalar_rf_pkg.sv
// Shared definitions for the scalar register-file writeback path.
package scalar_rf_pkg;

   localparam int unsigned REG_ADDR_W   = 5;
   localparam int unsigned NUM_REGS     = 32;
   localparam int unsigned COMMIT_CNT_W = 16;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      DONE
   } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded index, searching from a rotating pointer.
module rr_arbiter #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   cand;

   // Extra MSB on cand keeps ptr+k from overflowing before the modulo wrap.
   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(N)) begin
            cand = cand - (IDX_W+1)'(N);
         end
         if (!gnt_valid && !rst && req[cand[IDX_W-1:0]]) begin
            gnt[cand[IDX_W-1:0]] = 1'b1;
            gnt_idx              = cand[IDX_W-1:0];
            gnt_valid            = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_valid) begin
         ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/scalar_wb_arbiter.sv
// Scalar RF writeback arbiter with pending-write scoreboard, hazard flags and drain FSM.
module scalar_wb_arbiter
   import scalar_rf_pkg::*;
#(
   parameter int unsigned WIDTH = 19,
   parameter int unsigned N_REQ = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [REG_ADDR_W*N_REQ-1:0]   req_rd,
   input  logic [WIDTH*N_REQ-1:0]        req_wd,
   output logic [N_REQ-1:0]              req_ready,
   output logic                          wr_en,
   output logic [REG_ADDR_W-1:0]         wr_addr,
   output logic [WIDTH-1:0]              wr_data,
   input  logic                          claim_valid,
   input  logic [REG_ADDR_W-1:0]         claim_rd,
   output logic                          claim_ready,
   input  logic [REG_ADDR_W-1:0]         rs1,
   input  logic [REG_ADDR_W-1:0]         rs2,
   input  logic [REG_ADDR_W-1:0]         rs3,
   output logic                          haz1,
   output logic                          haz2,
   output logic                          haz3,
   input  logic                          drain_req,
   output logic                          drained,
   output logic [COMMIT_CNT_W-1:0]       commit_cnt
);

   localparam int unsigned IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0]        gnt_idx;
   logic                    gnt_valid;
   logic [REG_ADDR_W-1:0]   sel_rd;
   logic [WIDTH-1:0]        sel_wd;

   logic                    wr_en_q, wr_en_d;
   reg_addr_t               wr_addr_q, wr_addr_d;
   logic [WIDTH-1:0]        wr_data_q, wr_data_d;
   logic [NUM_REGS-1:0]     pending_q, pending_d;
   logic [COMMIT_CNT_W-1:0] commit_cnt_q, commit_cnt_d;
   wb_state_t               state_q, state_d;
   logic                    drained_q, drained_d;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid),
      .gnt       (req_ready),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_comb begin
      sel_rd = req_rd[32'(gnt_idx) * REG_ADDR_W +: REG_ADDR_W];
      sel_wd = req_wd[32'(gnt_idx) * WIDTH +: WIDTH];
   end

   assign claim_ready = claim_valid & ~pending_q[claim_rd] & (state_q == IDLE) & ~rst;

   // No bypass: the pending bit drops on the same edge the RF captures the data.
   assign haz1 = pending_q[rs1];
   assign haz2 = pending_q[rs2];
   assign haz3 = pending_q[rs3];

   always_comb begin
      wr_en_d   = gnt_valid;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (gnt_valid) begin
         wr_addr_d = sel_rd;
         wr_data_d = sel_wd;
      end
   end

   // Commit clears before claim sets, so a same-register claim is refused via the old bit.
   always_comb begin
      pending_d    = pending_q;
      commit_cnt_d = commit_cnt_q;
      if (wr_en_q) begin
         pending_d[wr_addr_q] = 1'b0;
         if (commit_cnt_q != '1) begin
            commit_cnt_d = commit_cnt_q + 1'b1;
         end
      end
      if (claim_ready) begin
         pending_d[claim_rd] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (drain_req) state_d = DRAIN;
         end
         DRAIN: begin
            if (pending_q == '0 && !wr_en_q && req_valid == '0) state_d = DONE;
         end
         DONE: begin
            if (!drain_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      drained_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         pending_q    <= '0;
         commit_cnt_q <= '0;
         state_q      <= IDLE;
         drained_q    <= 1'b0;
      end else begin
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         pending_q    <= pending_d;
         commit_cnt_q <= commit_cnt_d;
         state_q      <= state_d;
         drained_q    <= drained_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign commit_cnt = commit_cnt_q;
   assign drained    = drained_q;

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Self-checking bench: behavioural model compared every negedge plus directed literal checks.
module tb_scalar_wb_arbiter;

   localparam int W = 19;
   localparam int N = 3;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [5*N-1:0]    req_rd;
   logic [W*N-1:0]    req_wd;
   logic [N-1:0]      req_ready;
   logic              wr_en;
   logic [4:0]        wr_addr;
   logic [W-1:0]      wr_data;
   logic              claim_valid;
   logic [4:0]        claim_rd;
   logic              claim_ready;
   logic [4:0]        rs1, rs2, rs3;
   logic              haz1, haz2, haz3;
   logic              drain_req;
   logic              drained;
   logic [15:0]       commit_cnt;

   int tests = 0;
   int fails = 0;

   scalar_wb_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_rd(req_rd), .req_wd(req_wd), .req_ready(req_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_valid(claim_valid), .claim_rd(claim_rd), .claim_ready(claim_ready),
      .rs1(rs1), .rs2(rs2), .rs3(rs3), .haz1(haz1), .haz2(haz2), .haz3(haz3),
      .drain_req(drain_req), .drained(drained), .commit_cnt(commit_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [31:0]    m_pend  = '0;
   int           m_rr    = 0;
   bit           m_wen   = 1'b0;
   logic [4:0]   m_waddr = '0;
   logic [W-1:0] m_wdata = '0;
   int           m_cnt   = 0;
   int           m_st    = 0;   // 0 idle, 1 draining, 2 done

   function automatic int m_grant(input logic [N-1:0] v, input int rr);
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      int g;
      bit cl;
      if (rst) begin
         m_pend = '0; m_rr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
         m_cnt = 0; m_st = 0;
      end else begin
         g  = m_grant(req_valid, m_rr);
         cl = claim_valid && !m_pend[claim_rd] && (m_st == 0);
         if (m_st == 0 && drain_req) m_st = 1;
         else if (m_st == 1 && m_pend == 0 && !m_wen && req_valid == 0) m_st = 2;
         else if (m_st == 2 && !drain_req) m_st = 0;
         if (m_wen) begin
            m_pend[m_waddr] = 1'b0;
            if (m_cnt < 65535) m_cnt++;
         end
         if (cl) m_pend[claim_rd] = 1'b1;
         if (g >= 0) begin
            m_wen   = 1'b1;
            m_waddr = req_rd[g*5 +: 5];
            m_wdata = req_wd[g*W +: W];
            m_rr    = (g + 1) % N;
         end else begin
            m_wen = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      int g;
      logic [N-1:0] eg;
      forever begin
         @(negedge clk);
         g  = m_grant(req_valid, m_rr);
         eg = '0;
         if (!rst && g >= 0) eg[g] = 1'b1;
         check("m_req_ready", 32'(req_ready), 32'(eg));
         check("m_claim_ready", 32'(claim_ready),
               32'(!rst && claim_valid && !m_pend[claim_rd] && m_st == 0));
         check("m_haz1", 32'(haz1), 32'(m_pend[rs1]));
         check("m_haz2", 32'(haz2), 32'(m_pend[rs2]));
         check("m_haz3", 32'(haz3), 32'(m_pend[rs3]));
         check("m_wr_en", 32'(wr_en), 32'(m_wen));
         check("m_wr_addr", 32'(wr_addr), 32'(m_waddr));
         check("m_wr_data", 32'(wr_data), 32'(m_wdata));
         check("m_commit_cnt", 32'(commit_cnt), 32'(m_cnt));
         check("m_drained", 32'(drained), 32'(m_st == 2));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; req_valid = '0; req_rd = '0; req_wd = '0;
      claim_valid = 1'b0; claim_rd = '0; rs1 = '0; rs2 = '0; rs3 = '0; drain_req = 1'b0;
      step(); step();
      rst = 1'b0;
      step();
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_cnt", 32'(commit_cnt), 32'd0);
      check("rst_drained", 32'(drained), 32'd0);

      // Round robin over three held requesters
      req_rd = {5'd3, 5'd2, 5'd1};
      req_wd = {19'h03333, 19'h02222, 19'h01111};
      req_valid = 3'b111;
      #1 check("rr_g0", 32'(req_ready), 32'b001);
      step();
      check("rr_addr1", 32'(wr_addr), 32'd1);
      check("rr_g1", 32'(req_ready), 32'b010);
      step();
      check("rr_addr2", 32'(wr_addr), 32'd2);
      check("rr_g2", 32'(req_ready), 32'b100);
      step();
      check("rr_addr3", 32'(wr_addr), 32'd3);
      check("rr_g3", 32'(req_ready), 32'b001);
      step();
      check("rr_addr4", 32'(wr_addr), 32'd1);
      check("rr_data4", 32'(wr_data), 32'h01111);
      req_valid = '0;
      step();
      check("rr_cnt", 32'(commit_cnt), 32'd4);

      // Scoreboard hazard on r5
      claim_valid = 1'b1; claim_rd = 5'd5; rs1 = 5'd5;
      #1 check("haz_claim", 32'(claim_ready), 32'd1);
      step();
      claim_valid = 1'b0;
      #1 check("haz_set", 32'(haz1), 32'd1);
      req_rd[5 +: 5] = 5'd5; req_wd[W +: W] = 19'h7ABCD; req_valid = 3'b010;
      step();
      req_valid = '0;
      check("haz_wen", 32'(wr_en), 32'd1);
      check("haz_wdata", 32'(wr_data), 32'h7ABCD);
      check("haz_still", 32'(haz1), 32'd1);
      step();
      check("haz_clear", 32'(haz1), 32'd0);

      // WAW claim on the commit edge of the same register
      claim_valid = 1'b1; claim_rd = 5'd7;
      step();
      claim_valid = 1'b0;
      req_rd[0 +: 5] = 5'd7; req_valid = 3'b001;
      step();
      req_valid = '0;
      claim_valid = 1'b1; claim_rd = 5'd7;
      #1 check("waw_refused", 32'(claim_ready), 32'd0);
      step();
      check("waw_retry", 32'(claim_ready), 32'd1);
      step();
      claim_valid = 1'b0; rs2 = 5'd7;
      #1 check("waw_pending", 32'(haz2), 32'd1);
      req_valid = 3'b001;
      step();
      req_valid = '0;
      step(); step();

      // Drain with pending r3 and a queued write to r3
      claim_valid = 1'b1; claim_rd = 5'd3;
      step();
      claim_valid = 1'b0;
      req_rd[0 +: 5] = 5'd3; req_valid = 3'b001; drain_req = 1'b1;
      #1 check("drn_grant", 32'(req_ready), 32'b001);
      step();
      req_valid = '0; claim_valid = 1'b1; claim_rd = 5'd9;
      #1 check("drn_claim_blk", 32'(claim_ready), 32'd0);
      check("drn_not_yet", 32'(drained), 32'd0);
      step();
      check("drn_commit_edge", 32'(drained), 32'd0);
      step();
      check("drn_done", 32'(drained), 32'd1);
      check("drn_done_blk", 32'(claim_ready), 32'd0);
      drain_req = 1'b0; claim_valid = 1'b0;
      step();
      check("drn_exit", 32'(drained), 32'd0);
      claim_valid = 1'b1;
      #1 check("drn_idle_claim", 32'(claim_ready), 32'd1);
      claim_valid = 1'b0;

      // Reset mid-traffic with every register pending
      for (int i = 0; i < 32; i++) begin
         claim_valid = 1'b1; claim_rd = 5'(i);
         step();
      end
      claim_valid = 1'b0; rs1 = 5'd5;
      req_rd = {5'd3, 5'd2, 5'd1}; req_valid = 3'b111;
      #1 check("rst_all_pend", 32'(haz1), 32'd1);
      step();
      rst = 1'b1;
      #1 check("rstm_ready", 32'(req_ready), 32'd0);
      check("rstm_wen", 32'(wr_en), 32'd0);
      check("rstm_haz", 32'(haz1), 32'd0);
      step(); step();
      rst = 1'b0;
      #1 check("rstm_first", 32'(req_ready), 32'b001);
      step();
      req_valid = '0;
      step(); step();

      // Saturating commit counter
      req_rd[0 +: 5] = 5'd0; req_valid = 3'b001;
      repeat (65540) step();
      req_valid = '0;
      step(); step();
      check("sat_cnt", 32'(commit_cnt), 32'hFFFF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
